// File: rtl/dma_mc_cmdq_arb_if.sv
// Granted-command port of the multi-channel DMA command queue.
// The arbiter drives it as master; the transfer controller is the slave.
interface dma_mc_cmdq_arb_if #(
  parameter int CMD_W = 136,
  parameter int CW    = 1
);
  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;
  logic [CW-1:0]    out_chan;

  modport master (
    output out_valid,
    output out_cmd,
    output out_chan,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_cmd,
    input  out_chan,
    output out_ready
  );
endinterface

// File: rtl/dma_mc_cmdq_arb.sv
// Multi-channel DMA command queue: per-channel FIFOs with sticky status,
// drained round-robin into one registered valid/ready command port.
module dma_mc_cmdq_arb #(
  parameter int NUM_CHAN          = 2,
  parameter int SRC_ADDR_WIDTH    = 48,
  parameter int DST_ADDR_WIDTH    = 48,
  parameter int XFER_LENGTH_WIDTH = 40,
  parameter int CMDQ_DEPTH        = 16,
  localparam int CMD_W = SRC_ADDR_WIDTH + DST_ADDR_WIDTH
                       + XFER_LENGTH_WIDTH,
  localparam int UW    = $clog2(CMDQ_DEPTH) + 1,
  localparam int CW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CHAN-1:0]       new_cmd,
  input  logic [NUM_CHAN*CMD_W-1:0] cmd_in,
  input  logic [NUM_CHAN-1:0]       cancel,
  input  logic [NUM_CHAN-1:0]       sclr,
  input  logic [NUM_CHAN-1:0]       clear_sticky,
  dma_mc_cmdq_arb_if.master         out_if,
  output logic [NUM_CHAN-1:0]       empty,
  output logic [NUM_CHAN-1:0]       full,
  output logic [NUM_CHAN-1:0]       underflow,
  output logic [NUM_CHAN-1:0]       overflow,
  output logic [NUM_CHAN*UW-1:0]    usedw,
  output logic [NUM_CHAN*UW-1:0]    usedw_hwm
);

  localparam int AW = $clog2(CMDQ_DEPTH);

  logic [CMD_W-1:0]    r_mem [NUM_CHAN][CMDQ_DEPTH];
  logic [AW-1:0]       r_wr  [NUM_CHAN];
  logic [AW-1:0]       r_rd  [NUM_CHAN];
  logic [UW-1:0]       r_cnt [NUM_CHAN];
  logic [UW-1:0]       r_hwm [NUM_CHAN];
  logic [NUM_CHAN-1:0] r_empty;
  logic [NUM_CHAN-1:0] r_full;
  logic [NUM_CHAN-1:0] r_udf;
  logic [NUM_CHAN-1:0] r_ovf;
  logic [CW-1:0]       r_last;

  logic [NUM_CHAN-1:0] w_elig;
  logic [NUM_CHAN-1:0] w_push;
  logic [NUM_CHAN-1:0] w_ovf_set;
  logic [NUM_CHAN-1:0] w_udf_set;
  logic [NUM_CHAN-1:0] w_pop;
  logic [UW-1:0]       w_cnt_nx [NUM_CHAN];
  logic [UW-1:0]       w_hwm_nx [NUM_CHAN];
  logic                w_load;
  logic                w_found;
  logic [CW-1:0]       w_gnt;
  logic [CMD_W-1:0]    w_head;

  assign w_elig = ~r_empty & ~cancel & ~sclr;
  assign w_load = ~out_if.out_valid | out_if.out_ready;
  assign w_head = r_mem[w_gnt][r_rd[w_gnt]];

  // Scan from farthest to nearest so the first hit after r_last wins.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = NUM_CHAN; k >= 1; k--) begin
      j = int'(r_last) + k;
      if (j >= NUM_CHAN) j = j - NUM_CHAN;
      if (w_elig[CW'(j)]) begin
        w_found = 1'b1;
        w_gnt   = CW'(j);
      end
    end
  end

  always_comb begin
    w_push    = '0;
    w_ovf_set = '0;
    w_udf_set = '0;
    w_pop     = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      w_push[i]    = new_cmd[i] & ~r_full[i] & ~sclr[i];
      w_ovf_set[i] = new_cmd[i] & r_full[i] & ~sclr[i];
      w_udf_set[i] = cancel[i] & r_empty[i] & ~sclr[i];
      w_pop[i]     = (cancel[i] & ~r_empty[i] & ~sclr[i])
                   | (w_load & w_found & (w_gnt == CW'(i)));
      w_cnt_nx[i]  = '0;
      w_hwm_nx[i]  = '0;
      if (!sclr[i]) begin
        w_cnt_nx[i] = r_cnt[i] + UW'(w_push[i]) - UW'(w_pop[i]);
        if (clear_sticky[i] || (w_cnt_nx[i] > r_hwm[i]))
          w_hwm_nx[i] = w_cnt_nx[i];
        else
          w_hwm_nx[i] = r_hwm[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (w_push[i])
        r_mem[i][r_wr[i]] <= cmd_in[i*CMD_W +: CMD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
        r_hwm[i] <= '0;
      end
      r_empty          <= '1;
      r_full           <= '0;
      r_udf            <= '0;
      r_ovf            <= '0;
      r_last           <= CW'(NUM_CHAN - 1);
      out_if.out_valid <= 1'b0;
      out_if.out_cmd   <= '0;
      out_if.out_chan  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        r_cnt[i]   <= w_cnt_nx[i];
        r_hwm[i]   <= w_hwm_nx[i];
        r_empty[i] <= (w_cnt_nx[i] == '0);
        r_full[i]  <= (w_cnt_nx[i] == UW'(CMDQ_DEPTH));
        if (sclr[i]) begin
          r_wr[i]  <= '0;
          r_rd[i]  <= '0;
          r_udf[i] <= 1'b0;
          r_ovf[i] <= 1'b0;
        end else begin
          r_wr[i]  <= r_wr[i] + AW'(w_push[i]);
          r_rd[i]  <= r_rd[i] + AW'(w_pop[i]);
          // A same-cycle set event beats clear_sticky.
          r_udf[i] <= w_udf_set[i] | (r_udf[i] & ~clear_sticky[i]);
          r_ovf[i] <= w_ovf_set[i] | (r_ovf[i] & ~clear_sticky[i]);
        end
      end
      if (w_load) begin
        out_if.out_valid <= w_found;
        if (w_found) begin
          out_if.out_cmd  <= w_head;
          out_if.out_chan <= w_gnt;
          r_last          <= w_gnt;
        end
      end
    end
  end

  assign empty     = r_empty;
  assign full      = r_full;
  assign underflow = r_udf;
  assign overflow  = r_ovf;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_out
    assign usedw[g*UW +: UW]     = r_cnt[g];
    assign usedw_hwm[g*UW +: UW] = r_hwm[g];
  end

endmodule

// File: tb/tb_dma_mc_cmdq_arb.sv
// Bench for dma_mc_cmdq_arb: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_dma_mc_cmdq_arb;
  localparam int NC = 2;
  localparam int CMD_W = 136;
  localparam int DEPTH = 16;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef struct {
    logic [1:0] nc;
    logic [1:0] cn;
    logic [1:0] sc;
    logic [1:0] cs;
    logic       rdy;
    logic       ev;
    logic       ech;
    logic [4:0] eu0;
    logic [4:0] eu1;
    logic [1:0] eudf;
    logic [1:0] eovf;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      nc, cn, sc, cs;
  logic            rdy;
  logic [2*CMD_W-1:0] cin;
  logic [1:0]      empty, full, udf, ovf;
  logic [9:0]      usedw, hwm;

  int n_err = 0;
  int n_chk = 0;

  cmd_t mq [NC][$];
  int   m_hwm [NC];
  logic [1:0] m_udf, m_ovf;
  bit   m_v;
  cmd_t m_cmd;
  int   m_chan, m_last;

  dma_mc_cmdq_arb_if #(.CMD_W(CMD_W), .CW(1)) bus ();
  assign bus.out_ready = rdy;

  dma_mc_cmdq_arb dut (
    .clk          (clk),
    .reset        (rst),
    .new_cmd      (nc),
    .cmd_in       (cin),
    .cancel       (cn),
    .sclr         (sc),
    .clear_sticky (cs),
    .out_if       (bus),
    .empty        (empty),
    .full         (full),
    .underflow    (udf),
    .overflow     (ovf),
    .usedw        (usedw),
    .usedw_hwm    (hwm)
  );

  always #5 clk = ~clk;

  function automatic cmd_t pd(input int a, input int b);
    return {48'(a), 48'(b), 40'(a * 3 + b)};
  endfunction

  function automatic cmd_t rnd();
    return cmd_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic chk(input string nm, input cmd_t act, input cmd_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      m_hwm[i] = 0;
    end
    m_udf = '0;
    m_ovf = '0;
    m_v = 0;
    m_cmd = '0;
    m_chan = 0;
    m_last = NC - 1;
  endtask

  task automatic model_step();
    bit ld, found, os, us;
    int g, j, pre;
    if (rst) begin
      model_reset();
      return;
    end
    ld = !m_v || rdy;
    found = 0;
    g = 0;
    for (int k = 1; k <= NC; k++) begin
      j = (m_last + k) % NC;
      if (!found && mq[j].size() > 0 && !cn[j] && !sc[j]) begin
        found = 1;
        g = j;
      end
    end
    if (ld) begin
      m_v = found;
      if (found) begin
        m_cmd = mq[g][0];
        m_chan = g;
        m_last = g;
      end
    end
    for (int i = 0; i < NC; i++) begin
      pre = mq[i].size();
      os = 0;
      us = 0;
      if (sc[i]) begin
        mq[i].delete();
        m_ovf[i] = 0;
        m_udf[i] = 0;
        m_hwm[i] = 0;
      end else begin
        if (ld && found && g == i) void'(mq[i].pop_front());
        if (cn[i]) begin
          if (pre > 0) void'(mq[i].pop_front());
          else us = 1;
        end
        if (nc[i]) begin
          if (pre < DEPTH) mq[i].push_back(cin[i*CMD_W +: CMD_W]);
          else os = 1;
        end
        if (cs[i]) begin
          m_ovf[i] = 0;
          m_udf[i] = 0;
          m_hwm[i] = mq[i].size();
        end
        m_ovf[i] = m_ovf[i] | os;
        m_udf[i] = m_udf[i] | us;
        if (mq[i].size() > m_hwm[i]) m_hwm[i] = mq[i].size();
      end
    end
  endtask

  task automatic compare();
    logic [1:0] ee, ef;
    logic [9:0] eu, eh;
    for (int i = 0; i < NC; i++) begin
      ee[i] = (mq[i].size() == 0);
      ef[i] = (mq[i].size() == DEPTH);
      eu[i*5 +: 5] = 5'(mq[i].size());
      eh[i*5 +: 5] = 5'(m_hwm[i]);
    end
    chk("m_valid", cmd_t'(bus.out_valid), cmd_t'(m_v));
    if (m_v) begin
      chk("m_cmd", bus.out_cmd, m_cmd);
      chk("m_chan", cmd_t'(bus.out_chan), cmd_t'(m_chan));
    end
    chk("m_empty", cmd_t'(empty), cmd_t'(ee));
    chk("m_full", cmd_t'(full), cmd_t'(ef));
    chk("m_udf", cmd_t'(udf), cmd_t'(m_udf));
    chk("m_ovf", cmd_t'(ovf), cmd_t'(m_ovf));
    chk("m_usedw", cmd_t'(usedw), cmd_t'(eu));
    chk("m_hwm", cmd_t'(hwm), cmd_t'(eh));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    nc = '0;
    cn = '0;
    sc = '0;
    cs = '0;
  endtask

  vec_t tv [12];
  int emitted;
  int chans[$];
  int hs_step[$];
  cmd_t last_cmd;

  initial begin
    tv[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b0, 1'b0, 5'd1, 5'd0, 2'b00, 2'b00};
    tv[1]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00};
    tv[2]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00};
    tv[3]  = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b1,
               1'b0, 1'b0, 5'd0, 5'd0, 2'b10, 2'b00};
    tv[4]  = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b0,
               1'b0, 1'b0, 5'd0, 5'd1, 2'b00, 2'b00};
    tv[5]  = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b0,
               1'b0, 1'b0, 5'd0, 5'd1, 2'b00, 2'b00};
    tv[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
               1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00};
    tv[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b0,
               1'b1, 1'b1, 5'd1, 5'd1, 2'b00, 2'b00};
    tv[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
               1'b1, 1'b1, 5'd1, 5'd1, 2'b00, 2'b00};
    tv[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b1, 1'b0, 5'd0, 5'd1, 2'b00, 2'b00};
    tv[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00};
    tv[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00};

    model_reset();
    idle();
    rdy = 1'b0;
    cin = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", cmd_t'(bus.out_valid), cmd_t'(0));
    chk("rst_cmd", bus.out_cmd, cmd_t'(0));
    chk("rst_chan", cmd_t'(bus.out_chan), cmd_t'(0));
    chk("rst_empty", cmd_t'(empty), cmd_t'(2'b11));
    chk("rst_full", cmd_t'(full), cmd_t'(0));

    // Directed table
    for (int r = 0; r < 12; r++) begin
      nc = tv[r].nc;
      cn = tv[r].cn;
      sc = tv[r].sc;
      cs = tv[r].cs;
      rdy = tv[r].rdy;
      cin = {pd(r, 1), pd(r, 0)};
      step();
      chk("tv_valid", cmd_t'(bus.out_valid), cmd_t'(tv[r].ev));
      if (tv[r].ev)
        chk("tv_chan", cmd_t'(bus.out_chan), cmd_t'(tv[r].ech));
      if (r == 6)
        chk("tv_cancel_next", bus.out_cmd, pd(5, 1));
      chk("tv_used0", cmd_t'(usedw[4:0]), cmd_t'(tv[r].eu0));
      chk("tv_used1", cmd_t'(usedw[9:5]), cmd_t'(tv[r].eu1));
      chk("tv_udf", cmd_t'(udf), cmd_t'(tv[r].eudf));
      chk("tv_ovf", cmd_t'(ovf), cmd_t'(tv[r].eovf));
    end
    chk("tv_hwm0", cmd_t'(hwm[4:0]), cmd_t'(1));

    // Overflow of channel 0 with the port stalled
    idle();
    rdy = 1'b0;
    for (int k = 0; k < 18; k++) begin
      nc = 2'b01;
      cin = {pd(0, 0), pd(100 + k, 0)};
      step();
    end
    idle();
    chk("ovf_full", cmd_t'(full[0]), cmd_t'(1));
    chk("ovf_used", cmd_t'(usedw[4:0]), cmd_t'(16));
    chk("ovf_flag", cmd_t'(ovf[0]), cmd_t'(1));
    cs = 2'b01;
    step();
    idle();
    chk("ovf_clr", cmd_t'(ovf[0]), cmd_t'(0));
    chk("ovf_hwm", cmd_t'(hwm[4:0]), cmd_t'(16));
    rdy = 1'b1;
    emitted = 0;
    last_cmd = '0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        emitted++;
        last_cmd = bus.out_cmd;
      end
      step();
    end
    chk("ovf_emitted", cmd_t'(emitted), cmd_t'(17));
    chk("ovf_last", last_cmd, pd(116, 0));

    // Round robin, back to back
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nc = 2'b11;
      cin = {pd(200 + k, 1), pd(200 + k, 0)};
      step();
    end
    idle();
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) begin
        chans.push_back(int'(bus.out_chan));
        hs_step.push_back(k);
      end
      step();
    end
    chk("rr_count", cmd_t'(chans.size()), cmd_t'(6));
    if (hs_step.size() == 6)
      chk("rr_nobubble", cmd_t'(hs_step[5]), cmd_t'(5));
    for (int k = 1; k < chans.size(); k++)
      chk("rr_alt", cmd_t'(chans[k] != chans[k-1]), cmd_t'(1));

    // Stall with channel 1 flushed under a pending channel-1 command
    rdy = 1'b0;
    nc = 2'b11;
    cin = {pd(300, 1), pd(300, 0)};
    step();
    nc = 2'b10;
    cin = {pd(301, 1), pd(301, 0)};
    step();
    idle();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        sc = 2'b10;
        nc = 2'b10;
        cin = {pd(399, 1), pd(399, 0)};
      end else begin
        idle();
      end
      step();
      chk("stall_valid", cmd_t'(bus.out_valid), cmd_t'(1));
      chk("stall_cmd", bus.out_cmd, pd(300, 1));
      chk("stall_chan", cmd_t'(bus.out_chan), cmd_t'(1));
      if (k == 1) begin
        chk("sclr_used1", cmd_t'(usedw[9:5]), cmd_t'(0));
        chk("sclr_empty1", cmd_t'(empty[1]), cmd_t'(1));
        chk("sclr_ovf1", cmd_t'(ovf[1]), cmd_t'(0));
        chk("sclr_used0", cmd_t'(usedw[4:0]), cmd_t'(1));
      end
    end
    idle();
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Reset in the middle of traffic
    rdy = 1'b0;
    nc = 2'b11;
    cin = {pd(500, 1), pd(500, 0)};
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", cmd_t'(bus.out_valid), cmd_t'(0));
    chk("mrst_empty", cmd_t'(empty), cmd_t'(2'b11));
    chk("mrst_used", cmd_t'(usedw), cmd_t'(0));
    nc = 2'b11;
    cin = {pd(600, 1), pd(600, 0)};
    step();
    idle();
    rdy = 1'b1;
    step();
    chk("mrst_valid2", cmd_t'(bus.out_valid), cmd_t'(1));
    chk("mrst_chan", cmd_t'(bus.out_chan), cmd_t'(0));
    chk("mrst_cmd", bus.out_cmd, pd(600, 0));

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom % 250) == 0;
      nc = {($urandom % 10) < 6, ($urandom % 10) < 6};
      cn = {($urandom % 12) == 0, ($urandom % 12) == 0};
      sc = {($urandom % 40) == 0, ($urandom % 40) == 0};
      cs = {($urandom % 20) == 0, ($urandom % 20) == 0};
      rdy = ($urandom % 10) < 4;
      cin = {rnd(), rnd()};
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
